// File: rtl/exp7_arbitro_som.sv
`default_nettype none
// ============================================================================
// Module      : exp7_arbitro_som
// Description : Fixed-priority (fim > jog > mem) buzzer/LED arbiter with timed
//               tone, pause, cancel and one-entry pending queue per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module exp7_arbitro_som #(
  parameter int DURACAO   = 500,
  parameter int INTERVALO = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_mem,
  input  logic [3:0] cod_mem,
  input  logic       req_jog,
  input  logic [3:0] cod_jog,
  input  logic       req_fim,
  input  logic [3:0] cod_fim,
  input  logic       pausa,
  input  logic       cancelar,
  output logic [2:0] grant,
  output logic       som_ativo,
  output logic [3:0] codigo_som,
  output logic [3:0] leds,
  output logic       fim_mem,
  output logic       fim_jog,
  output logic       fim_fim,
  output logic       ocupado,
  output logic       db_descartado,
  output logic [1:0] db_estado
);

  localparam logic [15:0] c_dur_ultimo = 16'(DURACAO - 1);
  localparam logic [15:0] c_int_ultimo = 16'(INTERVALO - 1);

  typedef enum logic [1:0] {
    ST_OCIOSO    = 2'd0,
    ST_TOCANDO   = 2'd1,
    ST_INTERVALO = 2'd2
  } estado_t;

  estado_t     r_estado,    w_estado_n;
  logic [15:0] r_cnt,       w_cnt_n;
  logic [2:0]  r_pend,      w_pend_n;
  logic [3:0]  r_cod_mem,   w_cod_mem_n;
  logic [3:0]  r_cod_jog,   w_cod_jog_n;
  logic [3:0]  r_cod_fim,   w_cod_fim_n;
  logic [2:0]  r_dono,      w_dono_n;
  logic [3:0]  r_cod_ativo, w_cod_ativo_n;
  logic        r_descartado, w_descartado_n;

  logic [2:0]  w_req;
  logic [2:0]  w_novo;
  logic [2:0]  w_pend_ef;
  logic [2:0]  w_sel;
  logic [3:0]  w_cod_sel;
  logic        w_arbitrar;

  // Requests arriving this cycle take part in any arbitration on the same edge.
  assign w_req     = {req_fim, req_jog, req_mem};
  assign w_novo    = w_req & ~r_pend;
  assign w_pend_ef = r_pend | w_req;

  always_comb begin
    w_sel     = 3'b000;
    w_cod_sel = 4'd0;
    if (w_pend_ef[2]) begin
      w_sel     = 3'b100;
      w_cod_sel = r_pend[2] ? r_cod_fim : cod_fim;
    end else if (w_pend_ef[1]) begin
      w_sel     = 3'b010;
      w_cod_sel = r_pend[1] ? r_cod_jog : cod_jog;
    end else if (w_pend_ef[0]) begin
      w_sel     = 3'b001;
      w_cod_sel = r_pend[0] ? r_cod_mem : cod_mem;
    end
  end

  always_comb begin
    w_estado_n     = r_estado;
    w_cnt_n        = r_cnt;
    w_pend_n       = r_pend | w_novo;
    w_cod_mem_n    = w_novo[0] ? cod_mem : r_cod_mem;
    w_cod_jog_n    = w_novo[1] ? cod_jog : r_cod_jog;
    w_cod_fim_n    = w_novo[2] ? cod_fim : r_cod_fim;
    w_dono_n       = r_dono;
    w_cod_ativo_n  = r_cod_ativo;
    w_descartado_n = |(w_req & r_pend);
    w_arbitrar     = 1'b0;

    case (r_estado)
      ST_OCIOSO: begin
        w_cnt_n    = 16'd0;
        w_arbitrar = |w_pend_ef;
      end
      ST_TOCANDO: begin
        if (!pausa) begin
          if (r_cnt == c_dur_ultimo) begin
            w_estado_n = ST_INTERVALO;
            w_cnt_n    = 16'd0;
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
      end
      ST_INTERVALO: begin
        if (r_cnt == c_int_ultimo) begin
          w_cnt_n    = 16'd0;
          w_arbitrar = |w_pend_ef;
          if (!(|w_pend_ef)) begin
            w_estado_n = ST_OCIOSO;
          end
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      default: begin
        w_estado_n = ST_OCIOSO;
        w_cnt_n    = 16'd0;
      end
    endcase

    if (w_arbitrar) begin
      w_estado_n    = ST_TOCANDO;
      w_dono_n      = w_sel;
      w_cod_ativo_n = w_cod_sel;
      w_pend_n      = w_pend_n & ~w_sel;
    end

    // Cancel wins over everything except reset; same-cycle requests vanish silently.
    if (cancelar) begin
      w_estado_n     = ST_OCIOSO;
      w_cnt_n        = 16'd0;
      w_pend_n       = 3'b000;
      w_cod_mem_n    = r_cod_mem;
      w_cod_jog_n    = r_cod_jog;
      w_cod_fim_n    = r_cod_fim;
      w_descartado_n = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado     <= ST_OCIOSO;
      r_cnt        <= 16'd0;
      r_pend       <= 3'b000;
      r_cod_mem    <= 4'd0;
      r_cod_jog    <= 4'd0;
      r_cod_fim    <= 4'd0;
      r_dono       <= 3'b000;
      r_cod_ativo  <= 4'd0;
      r_descartado <= 1'b0;
    end else begin
      r_estado     <= w_estado_n;
      r_cnt        <= w_cnt_n;
      r_pend       <= w_pend_n;
      r_cod_mem    <= w_cod_mem_n;
      r_cod_jog    <= w_cod_jog_n;
      r_cod_fim    <= w_cod_fim_n;
      r_dono       <= w_dono_n;
      r_cod_ativo  <= w_cod_ativo_n;
      r_descartado <= w_descartado_n;
    end
  end

  assign grant         = (r_estado == ST_TOCANDO) ? r_dono : 3'b000;
  assign som_ativo     = (r_estado == ST_TOCANDO) && !pausa;
  assign codigo_som    = som_ativo ? r_cod_ativo : 4'd0;
  assign leds          = codigo_som;
  assign fim_mem       = (r_estado == ST_INTERVALO) && (r_cnt == 16'd0) && r_dono[0];
  assign fim_jog       = (r_estado == ST_INTERVALO) && (r_cnt == 16'd0) && r_dono[1];
  assign fim_fim       = (r_estado == ST_INTERVALO) && (r_cnt == 16'd0) && r_dono[2];
  assign ocupado       = (r_estado != ST_OCIOSO) || (|r_pend);
  assign db_descartado = r_descartado;
  assign db_estado     = r_estado;

endmodule
`default_nettype wire

// File: doc/exp7_arbitro_som.md
EXP7_ARBITRO_SOM -- requirements
Module: exp7_arbitro_som

Interface
REQ-001 Parameter DURACAO, default 500, tone/LED duration in clock cycles per grant, legal range 1..65535.
REQ-002 Parameter INTERVALO, default 100, silent gap in cycles after each grant, legal range 1..65535.
REQ-003 clock  input  1  single system clock, all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_mem  input  1  one-cycle request pulse from sequence display (priority 0, lowest).
REQ-006 cod_mem  input  4  code for req_mem, sampled with the pulse.
REQ-007 req_jog  input  1  one-cycle request pulse from player feedback (priority 1).
REQ-008 cod_jog  input  4  code for req_jog, sampled with the pulse.
REQ-009 req_fim  input  1  one-cycle request pulse from end-of-game alert (priority 2, highest).
REQ-010 cod_fim  input  4  code for req_fim, sampled with the pulse.
REQ-011 pausa  input  1  level; freezes the active grant and silences outputs.
REQ-012 cancelar  input  1  one-cycle pulse; drops all pending and active work.
REQ-013 grant  output  3  one-hot {fim,jog,mem} owner of the resource; 000 when none.
REQ-014 som_ativo  output  1  buzzer enable.
REQ-015 codigo_som  output  4  code of the active grant; 0 when som_ativo low.
REQ-016 leds  output  4  equals codigo_som while som_ativo high, else 0.
REQ-017 fim_mem, fim_jog, fim_fim  output  1 each  one-cycle completion pulses.
REQ-018 ocupado  output  1  high when state is not OCIOSO or any request is pending.
REQ-019 db_descartado  output  1  one-cycle pulse when a request is dropped.
REQ-020 db_estado  output  2  OCIOSO=0, TOCANDO=1, INTERVALO=2.

Function
REQ-021 Each requester SHALL own one pending flag and one 4-bit code register, set and loaded on the edge sampling its req pulse.
REQ-022 A req pulse SHALL be dropped, and db_descartado pulsed next cycle, when that requester's pending flag is already set; the stored code SHALL NOT change.
REQ-023 A req pulse from the requester currently granted SHALL be accepted as a new pending entry.
REQ-024 OCIOSO: when any pending flag is set, next state SHALL be TOCANDO, granting the highest-priority pending requester and clearing its pending flag on the same edge.
REQ-025 Latency: req pulse sampled at edge N into idle arbiter -> grant and som_ativo SHALL be high from edge N+1.
REQ-026 TOCANDO: 16-bit counter SHALL count active cycles; som_ativo SHALL stay high for exactly DURACAO non-paused cycles, then next state SHALL be INTERVALO.
REQ-027 While pausa is high in TOCANDO, the counter SHALL hold, som_ativo/codigo_som/leds SHALL be 0, and grant SHALL hold its value.
REQ-028 pausa SHALL have no effect in OCIOSO or INTERVALO.
REQ-029 The completion pulse of the granted requester SHALL be high during the first INTERVALO cycle only; grant SHALL be 000 during INTERVALO.
REQ-030 INTERVALO SHALL last exactly INTERVALO cycles, then next state SHALL be TOCANDO (per REQ-024 arbitration) if any pending flag is set, else OCIOSO.
REQ-031 Priority SHALL be fixed fim > jog > mem; arbitration SHALL occur only on entry to TOCANDO, with no preemption of an active grant.
REQ-032 Requests sampled on the same edge as arbitration SHALL participate in that arbitration.
REQ-033 cancelar SHALL, on the next edge, clear all pending flags, force OCIOSO, zero the counter, and suppress completion pulses; req pulses on the cancelar cycle SHALL be discarded without db_descartado.
REQ-034 Undefined db_estado encodings SHALL recover to OCIOSO on the next edge.

Reset
REQ-035 On a clock edge with reset high: state OCIOSO, pending flags and code registers 0, counter 0, all outputs 0; reset SHALL override cancelar and all requests.
REQ-036 Reset asserted mid-TOCANDO SHALL produce no completion pulse.

Verification (DURACAO=4, INTERVALO=2)
REQ-037 req_mem pulse, cod_mem=5, idle -> grant=001, leds=5, som_ativo high 4 cycles, fim_mem pulse in the following cycle, OCIOSO after 2 gap cycles.
REQ-038 req_mem and req_fim on same cycle (codes 1, 9) -> grant=100 code 9 first, then after gap grant=001 code 1; fim_fim before fim_mem.
REQ-039 req_jog while jog pending, codes 3 then 7 -> db_descartado one pulse; later playback shows code 3 only.
REQ-040 pausa high 3 cycles during 2nd TOCANDO cycle -> outputs 0 for 3 cycles, grant held, total som_ativo cycles still 4.
REQ-041 cancelar during TOCANDO with jog pending -> OCIOSO next cycle, ocupado=0, no fim_* pulses.
REQ-042 reset pulse mid-INTERVALO with mem pending -> all outputs 0, db_estado=0, no playback afterwards.
